// File: rtl/tracker_pkg.sv
// rtl/tracker_pkg.sv - shared types, widths and saturation helper for the tracker voice mixer
package tracker_pkg;

    localparam int PCM_W     = 16;
    localparam int VOL_MAX   = 64;
    localparam int PAN_MAX   = 16;
    localparam int V_W       = 17;
    localparam int CONTRIB_W = 18;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SCALE,
        ACC,
        OUT
    } mixer_state_t;

    function automatic logic signed [PCM_W-1:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[PCM_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tracker_voice_gain.sv
// rtl/tracker_voice_gain.sv - combinational volume/pan gain for one voice sample
module tracker_voice_gain
    import tracker_pkg::*;
(
    input  logic signed [PCM_W-1:0]     i_sample,
    input  logic        [6:0]           i_vol,
    input  logic        [4:0]           i_pan,
    output logic signed [CONTRIB_W-1:0] o_left,
    output logic signed [CONTRIB_W-1:0] o_right
);

    logic        [6:0]       w_vol_c;
    logic        [4:0]       w_pan_c;
    logic        [4:0]       w_pan_l;
    logic signed [23:0]      w_prod;
    logic signed [V_W-1:0]   w_v;
    logic signed [22:0]      w_lprod;
    logic signed [22:0]      w_rprod;

    assign w_vol_c = (i_vol > 7'(VOL_MAX)) ? 7'(VOL_MAX) : i_vol;
    assign w_pan_c = (i_pan > 5'(PAN_MAX)) ? 5'(PAN_MAX) : i_pan;
    assign w_pan_l = 5'(PAN_MAX) - w_pan_c;

    // Arithmetic shifts on the full-width products give floor rounding toward -inf.
    assign w_prod  = 24'(i_sample) * 24'($signed({1'b0, w_vol_c}));
    assign w_v     = V_W'(w_prod >>> 6);

    assign w_lprod = 23'(w_v) * 23'($signed({1'b0, w_pan_l}));
    assign w_rprod = 23'(w_v) * 23'($signed({1'b0, w_pan_c}));
    assign o_left  = CONTRIB_W'(w_lprod >>> 4);
    assign o_right = CONTRIB_W'(w_rprod >>> 4);

endmodule

// File: rtl/tracker_voice_mixer.sv
// rtl/tracker_voice_mixer.sv - per-frame voice fetch, gain, stereo accumulate and saturate
module tracker_voice_mixer
    import tracker_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_active_low,
    input  logic                    frame_tick,
    output logic                    voice_req,
    output logic [IDX_W-1:0]        voice_idx,
    input  logic                    voice_valid,
    input  logic signed [PCM_W-1:0] voice_sample,
    input  logic [6:0]              voice_volume,
    input  logic [4:0]              voice_pan,
    output logic signed [PCM_W-1:0] pcm_left,
    output logic signed [PCM_W-1:0] pcm_right,
    output logic                    pcm_valid,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int ACC_W = 18 + $clog2(NUM_VOICES);

    mixer_state_t r_state;
    mixer_state_t w_state_next;

    logic        [IDX_W-1:0]     r_voice_idx;
    logic signed [PCM_W-1:0]     r_sample;
    logic        [6:0]           r_vol;
    logic        [4:0]           r_pan;
    logic signed [CONTRIB_W-1:0] r_left;
    logic signed [CONTRIB_W-1:0] r_right;
    logic signed [ACC_W-1:0]     r_acc_l;
    logic signed [ACC_W-1:0]     r_acc_r;
    logic signed [PCM_W-1:0]     r_pcm_left;
    logic signed [PCM_W-1:0]     r_pcm_right;
    logic                        r_overrun;

    logic signed [CONTRIB_W-1:0] w_left;
    logic signed [CONTRIB_W-1:0] w_right;
    logic signed [ACC_W-1:0]     w_acc_l_next;
    logic signed [ACC_W-1:0]     w_acc_r_next;
    logic                        w_last_voice;

    tracker_voice_gain u_gain (
        .i_sample (r_sample),
        .i_vol    (r_vol),
        .i_pan    (r_pan),
        .o_left   (w_left),
        .o_right  (w_right)
    );

    assign w_last_voice = (r_voice_idx == IDX_W'(NUM_VOICES - 1));
    assign w_acc_l_next = r_acc_l + ACC_W'(r_left);
    assign w_acc_r_next = r_acc_r + ACC_W'(r_right);

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (frame_tick)  w_state_next = REQ;
            REQ:     if (voice_valid) w_state_next = SCALE;
            SCALE:   w_state_next = ACC;
            ACC:     w_state_next = w_last_voice ? OUT : REQ;
            OUT:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        voice_req = 1'b0;
        busy      = 1'b0;
        pcm_valid = 1'b0;
        case (r_state)
            REQ: begin
                voice_req = 1'b1;
                busy      = 1'b1;
            end
            SCALE, ACC: busy      = 1'b1;
            OUT:        pcm_valid = 1'b1;
            default: ;
        endcase
    end

    // pcm words load on the final ACC edge so they are already new while pcm_valid is high.
    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            r_voice_idx <= '0;
            r_sample    <= '0;
            r_vol       <= '0;
            r_pan       <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_pcm_left  <= '0;
            r_pcm_right <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_tick) begin
                        r_acc_l     <= '0;
                        r_acc_r     <= '0;
                        r_voice_idx <= '0;
                    end
                end
                REQ: begin
                    if (voice_valid) begin
                        r_sample <= voice_sample;
                        r_vol    <= voice_volume;
                        r_pan    <= voice_pan;
                    end
                end
                SCALE: begin
                    r_left  <= w_left;
                    r_right <= w_right;
                end
                ACC: begin
                    r_acc_l <= w_acc_l_next;
                    r_acc_r <= w_acc_r_next;
                    if (w_last_voice) begin
                        r_pcm_left  <= sat16(32'(w_acc_l_next));
                        r_pcm_right <= sat16(32'(w_acc_r_next));
                    end else begin
                        r_voice_idx <= r_voice_idx + IDX_W'(1);
                    end
                end
                OUT: r_voice_idx <= '0;
                default: ;
            endcase
        end
    end

    // Any tick outside IDLE is dropped and flagged; a set beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            r_overrun <= 1'b0;
        end else if (frame_tick && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign voice_idx = r_voice_idx;
    assign pcm_left  = r_pcm_left;
    assign pcm_right = r_pcm_right;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_tracker_voice_mixer.sv
// tb/tb_tracker_voice_mixer.sv - self-checking bench for tracker_voice_mixer
module tb_tracker_voice_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_active_low;
    logic               frame_tick;
    logic               voice_req;
    logic [2:0]         voice_idx;
    logic               voice_valid;
    logic signed [15:0] voice_sample;
    logic [6:0]         voice_volume;
    logic [4:0]         voice_pan;
    logic signed [15:0] pcm_left;
    logic signed [15:0] pcm_right;
    logic               pcm_valid;
    logic               busy;
    logic               overrun;
    logic               overrun_clr;

    logic               frame_tick_1;
    logic               voice_req_1;
    logic [0:0]         voice_idx_1;
    logic               voice_valid_1;
    logic signed [15:0] voice_sample_1;
    logic [6:0]         voice_volume_1;
    logic [4:0]         voice_pan_1;
    logic signed [15:0] pcm_left_1;
    logic signed [15:0] pcm_right_1;
    logic               pcm_valid_1;
    logic               busy_1;
    logic               overrun_1;
    logic               overrun_clr_1;

    tracker_voice_mixer #(.NUM_VOICES(8)) dut (
        .clk            (clk),
        .rst_active_low (rst_active_low),
        .frame_tick     (frame_tick),
        .voice_req      (voice_req),
        .voice_idx      (voice_idx),
        .voice_valid    (voice_valid),
        .voice_sample   (voice_sample),
        .voice_volume   (voice_volume),
        .voice_pan      (voice_pan),
        .pcm_left       (pcm_left),
        .pcm_right      (pcm_right),
        .pcm_valid      (pcm_valid),
        .busy           (busy),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr)
    );

    tracker_voice_mixer #(.NUM_VOICES(1)) dut1 (
        .clk            (clk),
        .rst_active_low (rst_active_low),
        .frame_tick     (frame_tick_1),
        .voice_req      (voice_req_1),
        .voice_idx      (voice_idx_1),
        .voice_valid    (voice_valid_1),
        .voice_sample   (voice_sample_1),
        .voice_volume   (voice_volume_1),
        .voice_pan      (voice_pan_1),
        .pcm_left       (pcm_left_1),
        .pcm_right      (pcm_right_1),
        .pcm_valid      (pcm_valid_1),
        .busy           (busy_1),
        .overrun        (overrun_1),
        .overrun_clr    (overrun_clr_1)
    );

    int total = 0;
    int bad   = 0;
    int src_sample [8];
    int src_vol    [8];
    int src_pan    [8];
    int src_delay  [8];
    int req_cycles [8];
    int pv_count   = 0;
    int wait_cnt   = 0;

    task automatic chk(input string tag, input integer got, input integer exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Voice source: answers requests after the programmed delay, drives junk otherwise.
    always @(negedge clk) begin
        if (voice_req) begin
            if (wait_cnt < src_delay[voice_idx]) begin
                wait_cnt++;
                voice_valid  = 1'b0;
                voice_sample = 16'($urandom);
                voice_volume = 7'($urandom);
                voice_pan    = 5'($urandom);
            end else begin
                voice_valid  = 1'b1;
                voice_sample = 16'(src_sample[voice_idx]);
                voice_volume = 7'(src_vol[voice_idx]);
                voice_pan    = 5'(src_pan[voice_idx]);
            end
        end else begin
            wait_cnt     = 0;
            voice_valid  = 1'($urandom_range(0, 1));
            voice_sample = 16'($urandom);
            voice_volume = 7'($urandom);
            voice_pan    = 5'($urandom);
        end
    end

    always @(negedge clk) begin
        if (voice_req) req_cycles[voice_idx]++;
        if (pcm_valid) pv_count++;
    end

    function automatic void model(output int l, output int r);
        int al, ar, vc, pc, v;
        al = 0;
        ar = 0;
        for (int i = 0; i < 8; i++) begin
            vc = (src_vol[i] > 64) ? 64 : src_vol[i];
            pc = (src_pan[i] > 16) ? 16 : src_pan[i];
            v  = (src_sample[i] * vc) >>> 6;
            al += (v * (16 - pc)) >>> 4;
            ar += (v * pc) >>> 4;
        end
        l = (al > 32767) ? 32767 : ((al < -32768) ? -32768 : al);
        r = (ar > 32767) ? 32767 : ((ar < -32768) ? -32768 : ar);
    endfunction

    task automatic set_all(input int s, input int v, input int p);
        for (int i = 0; i < 8; i++) begin
            src_sample[i] = s;
            src_vol[i]    = v;
            src_pan[i]    = p;
            src_delay[i]  = 0;
        end
    endtask

    task automatic rand_fill(input int max_delay);
        for (int i = 0; i < 8; i++) begin
            src_sample[i] = $signed(16'($urandom));
            src_vol[i]    = int'($urandom_range(0, 127));
            src_pan[i]    = int'($urandom_range(0, 31));
            src_delay[i]  = int'($urandom_range(0, max_delay));
        end
    endtask

    task automatic run_frame(input string tag);
        int el, er, c, exp_lat;
        model(el, er);
        exp_lat = 25;
        for (int i = 0; i < 8; i++) exp_lat += src_delay[i];
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        c = 1;
        while (!pcm_valid && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, "_lat"}, c, exp_lat);
        chk({tag, "_left"}, pcm_left, el);
        chk({tag, "_right"}, pcm_right, er);
        @(posedge clk); #1;
        chk({tag, "_pv_low"}, pcm_valid, 0);
        chk({tag, "_hold_l"}, pcm_left, el);
    endtask

    initial begin
        int c, rc0, rc3, pv0;
        rst_active_low = 1'b0;
        frame_tick     = 1'b0;
        overrun_clr    = 1'b0;
        frame_tick_1   = 1'b0;
        overrun_clr_1  = 1'b0;
        voice_valid_1  = 1'b1;
        voice_sample_1 = 16'sd1000;
        voice_volume_1 = 7'd64;
        voice_pan_1    = 5'd8;
        set_all(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", voice_req, 0);
        chk("rst_idx", voice_idx, 0);
        chk("rst_left", pcm_left, 0);
        chk("rst_right", pcm_right, 0);
        chk("rst_pv", pcm_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        rst_active_low = 1'b1;
        @(posedge clk); #1;

        frame_tick_1 = 1'b1;
        @(posedge clk); #1;
        frame_tick_1 = 1'b0;
        c = 1;
        while (!pcm_valid_1 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("n1_lat", c, 4);
        chk("n1_left", pcm_left_1, 500);
        chk("n1_right", pcm_right_1, 500);

        set_all(32767, 64, 0);
        run_frame("satp");
        set_all(-32768, 64, 0);
        run_frame("satn");
        set_all(0, 0, 0);
        src_sample[0] = -1; src_vol[0] = 1; src_pan[0] = 16;
        run_frame("floor");
        set_all(0, 0, 0);
        src_sample[2] = 64;   src_vol[2] = 100; src_pan[2] = 4;
        src_sample[5] = 1000; src_vol[5] = 64;  src_pan[5] = 31;
        run_frame("clamp");

        rand_fill(0);
        run_frame("zw");
        rc0 = req_cycles[0];
        rc3 = req_cycles[3];
        src_delay[3] = 5;
        run_frame("dly");
        chk("dly_req3", req_cycles[3] - rc3, 6);
        chk("dly_req0", req_cycles[0] - rc0, 1);

        for (int k = 0; k < 6; k++) begin
            rand_fill(3);
            run_frame($sformatf("rnd%0d", k));
        end

        pv0 = pv_count;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        chk("ovr_set", overrun, 1);
        repeat (60) @(posedge clk);
        #1;
        chk("ovr_one_pv", pv_count - pv0, 1);
        chk("ovr_idle", busy, 0);
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        frame_tick  = 1'b1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        frame_tick  = 1'b0;
        overrun_clr = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        repeat (60) @(posedge clk);
        #1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;

        set_all(1000, 64, 8);
        run_frame("pre_rst");
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        c = 0;
        while (!(voice_req && voice_idx == 3'd4) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rst_reach_v4", (c < 100) ? 1 : 0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_active_low = 1'b0;
        #1;
        chk("mid_rst_left", pcm_left, 0);
        chk("mid_rst_right", pcm_right, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_idx", voice_idx, 0);
        chk("mid_rst_req", voice_req, 0);
        @(posedge clk); #1;
        rst_active_low = 1'b1;
        @(posedge clk); #1;
        rc0 = req_cycles[0];
        rand_fill(1);
        run_frame("post_rst");
        chk("post_rst_v0", (req_cycles[0] - rc0 > 0) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tracker_voice_mixer.md
Name: tracker_voice_mixer

Overview:
- Upstream stage of the I2S PCM serializer; runs in the 12 MHz clock domain.
- On each 48 kHz frame tick, fetches one sample per tracker voice over a request/valid handshake and applies per-voice volume and pan.
- Sums all voices into stereo accumulators, saturates to 16-bit signed, and presents held pcm_left/pcm_right words to the serializer.

Parameters:
- NUM_VOICES, 8, number of voices mixed per frame (range 1..16)
- IDX_W, $clog2(NUM_VOICES) (min 1), width of voice_idx

Ports:
- clk  in  1  system clock (12 MHz)
- rst_active_low  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per output frame, synchronous to clk
- voice_req  out  1  sample request for voice voice_idx
- voice_idx  out  IDX_W  voice being fetched
- voice_valid  in  1  sample/volume/pan valid for voice_idx
- voice_sample  in  16  signed PCM sample
- voice_volume  in  7  volume 0..64; values above 64 clamp to 64
- voice_pan  in  5  pan 0 (hard left)..16 (hard right); values above 16 clamp to 16
- pcm_left  out  16  signed mixed left word, held between frames
- pcm_right  out  16  signed mixed right word, held between frames
- pcm_valid  out  1  one-cycle pulse when pcm_left/pcm_right update
- busy  out  1  high from frame start until pcm_valid
- overrun  out  1  sticky: frame_tick arrived while busy
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset state (async assert, sync release): all outputs 0, state IDLE, accumulators 0.
- IDLE: frame_tick=1 -> clear accL/accR, voice_idx=0, go to REQ, busy=1.
- REQ: voice_req=1 held until voice_valid=1 is sampled in the same cycle, then capture sample/volume/pan and go to SCALE. voice_valid while voice_req=0 is ignored.
- SCALE: v = (sample * vol_clamped) >>> 6, where >>> is arithmetic shift (floor toward -inf). v is 17 bits signed; go to ACC.
- ACC:
  - accL += (v * (16 - pan_clamped)) >>> 4.
  - accR += (v * pan_clamped) >>> 4.
  - If voice_idx == NUM_VOICES-1 go to OUT; otherwise increment voice_idx and go to REQ.
- OUT:
  - pcm_left = sat16(accL), pcm_right = sat16(accR), where sat16 clamps to [-32768, 32767].
  - pcm_valid=1 for this cycle only; busy=0; voice_idx=0; return to IDLE.
- Accumulator width: 17 + $clog2(NUM_VOICES) + 1 bits signed. It can never wrap internally.
- Latency with zero-wait source (voice_valid already high on the first REQ cycle): tick in cycle 0, pcm_valid in cycle 3*NUM_VOICES+1 (25 for NUM_VOICES=8). Each wait cycle in REQ adds 1.
- pcm_left/pcm_right change only in the OUT cycle; the serializer may sample them at any time.
- frame_tick while busy (including in the OUT cycle): the tick is dropped, overrun=1, and the current frame continues unaffected.
- Simultaneous overrun set and overrun_clr: set wins.
- Reset mid-frame: immediate return to reset state. The partial mix is discarded and pcm outputs go to 0.
- Volume 0 or fully panned-away voices contribute exactly 0.

Decomposition:
- Package tracker_pkg:
  - PCM_W=16, VOL_MAX=64, PAN_MAX=16.
  - mixer_state_t enum {IDLE, REQ, SCALE, ACC, OUT}.
  - Function sat16.
- Sub-module tracker_voice_gain (combinational):
  - Inputs: sample, vol, pan.
  - Function: clamps vol and pan, computes v, left and right contributions.
  - Registering is done in the parent per state.

Test Plan:
- NUM_VOICES=1: sample 1000, vol 64, pan 8, zero-wait -> pcm_left=500, pcm_right=500, pcm_valid exactly 4 cycles after tick.
- 8 voices, each sample 32767, vol 64, pan 0 -> pcm_left=32767 (saturated), pcm_right=0. Repeat with -32768 -> pcm_left=-32768.
- Sample -1, vol 1, pan 16 -> right = (-1 >>> 6) >>> 0 = -1, left=0 (floor rounding). Vol 100 with sample 64 -> treated as 64, output 64*pan share.
- voice_valid delayed 5 cycles for voice 3 only (8 voices, zero-wait otherwise) -> voice_req held 6 cycles, pcm_valid at cycle 30; values unchanged vs zero-wait run.
- frame_tick again 10 cycles after the first -> overrun=1, single pcm_valid. overrun_clr pulse -> overrun=0. Simultaneous clr and new overrun -> stays 1.
- Assert rst_active_low low during ACC of voice 4 -> all outputs 0 asynchronously. After release, a tick mixes from voice 0 with correct sums.
